// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Purpose: WIDTH-bit barrel shifter split into SW = log2(WIDTH) register
// stages. Stage k shifts by 2^k when bit k of the request's shift length is
// set, so a request needs exactly SW cycles from acceptance to out_valid.
// Every stage has its own valid bit and uses valid/ready flow control. The
// pipeline accepts one request per cycle and adds no bubbles. When the
// consumer stalls, the output holds and the upstream stages fill before
// in_ready drops.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       request present on in / sl / left_or_right / mode
//   in_ready       shifter accepts a request this cycle
//   in             operand, WIDTH bits
//   sl             shift length, 0..WIDTH-1
//   left_or_right  0 = left, 1 = right
//   mode           00 logical, 01 rotate, 10 arithmetic, 11 pass-through
//   out_valid      result present on out (and out_carry)
//   out_ready      consumer accepts the result this cycle
//   out            shifted result
//   out_carry      last bit shifted out (only with SHIFTER_CARRY_EN)
//
// Configuration: defining SHIFTER_CARRY_EN adds the out_carry port and one
// carry flop per stage. The default build (macro undefined) has no carry logic.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    sl,
  input  logic             left_or_right,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFTER_CARRY_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;
  localparam logic [1:0] MODE_PASS  = 2'b11;

  logic [SW-1:0] valid_vec;
  logic [SW-1:0] adv;

  assign in_ready = ~valid_vec[0] | adv[0];

  genvar k;
  for (k = 0; k < SW; k++) begin : g_stage
    localparam int AMT = 1 << k;

    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] nxt_data;
    logic [WIDTH-1:0] data_q;
    // Only the shift-length bits that this stage and later stages use
    // stay with the request.
    logic [SW-1:k]    src_sl;
    logic             src_dir;
    logic [1:0]       src_mode;
    logic             load;
    logic             valid_q;
`ifdef SHIFTER_CARRY_EN
    logic             src_carry;
    logic             nxt_carry;
    logic             carry_q;
`endif

    if (k == 0) begin : g_src
      assign src_data = in;
      assign src_sl   = sl;
      assign src_dir  = left_or_right;
      assign src_mode = mode;
      assign load     = in_valid & in_ready;
`ifdef SHIFTER_CARRY_EN
      assign src_carry = 1'b0;
`endif
    end else begin : g_src
      assign src_data = g_stage[k-1].data_q;
      assign src_sl   = g_stage[k-1].g_ctl.sl_q;
      assign src_dir  = g_stage[k-1].g_ctl.dir_q;
      assign src_mode = g_stage[k-1].g_ctl.mode_q;
      assign load     = adv[k-1];
`ifdef SHIFTER_CARRY_EN
      assign src_carry = g_stage[k-1].carry_q;
`endif
    end

    // A stage advances when the consumer takes the result, or when any
    // stage downstream of it has a free slot. Unrolling the recursion this
    // way avoids a combinational path through the adv vector itself.
    if (k == SW-1) begin : g_adv
      assign adv[k] = valid_q & out_ready;
    end else begin : g_adv
      assign adv[k] = valid_q & (out_ready | ~(&valid_vec[SW-1:k+1]));
    end
    assign valid_vec[k] = valid_q;

    always_comb begin
      nxt_data = src_data;
`ifdef SHIFTER_CARRY_EN
      nxt_carry = src_carry;
`endif
      if (src_sl[k] && (src_mode != MODE_PASS)) begin
        if (!src_dir) begin
          if (src_mode == MODE_ROT) begin
            nxt_data = {src_data[WIDTH-AMT-1:0], src_data[WIDTH-1 -: AMT]};
          end else begin
            // Arithmetic left is the same as logical left.
            nxt_data = {src_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
          end
        end else begin
          if (src_mode == MODE_ROT) begin
            nxt_data = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
          end else if (src_mode == MODE_ARITH) begin
            // The sign bit survives earlier arithmetic stages, so the
            // current MSB is still the operand's sign.
            nxt_data = {{AMT{src_data[WIDTH-1]}}, src_data[WIDTH-1:AMT]};
          end else begin
            nxt_data = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
          end
        end
`ifdef SHIFTER_CARRY_EN
        // The last stage that shifts determines the carry. For a rotate it
        // is the bit that has just wrapped round to the far end.
        if (src_mode == MODE_ROT) begin
          nxt_carry = src_dir ? nxt_data[WIDTH-1] : nxt_data[0];
        end else begin
          nxt_carry = src_dir ? src_data[AMT-1] : src_data[WIDTH-AMT];
        end
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
`ifdef SHIFTER_CARRY_EN
        carry_q <= 1'b0;
`endif
      end else if (load) begin
        valid_q <= 1'b1;
        data_q  <= nxt_data;
`ifdef SHIFTER_CARRY_EN
        carry_q <= nxt_carry;
`endif
      end else if (adv[k]) begin
        valid_q <= 1'b0;
      end
    end

    // The control fields are needed only while a later stage still has
    // to act on them.
    if (k < SW-1) begin : g_ctl
      logic [SW-1:k+1] sl_q;
      logic            dir_q;
      logic [1:0]      mode_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sl_q   <= '0;
          dir_q  <= 1'b0;
          mode_q <= 2'b00;
        end else if (load) begin
          sl_q   <= src_sl[SW-1:k+1];
          dir_q  <= src_dir;
          mode_q <= src_mode;
        end
      end
    end
  end

  assign out_valid = valid_vec[SW-1];
  assign out       = g_stage[SW-1].data_q;
`ifdef SHIFTER_CARRY_EN
  assign out_carry = g_stage[SW-1].carry_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] sl = '0;
  logic          left_or_right = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
`ifdef SHIFTER_CARRY_EN
  logic          out_carry;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_c[$];
  int in_count = 0;
  int out_count = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in(in_data),
    .sl(sl),
    .left_or_right(left_or_right),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SHIFTER_CARRY_EN
    .out_carry(out_carry),
`endif
    .out(out_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: {carry, result} computed directly from the shift rules.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input int s,
                                           input logic dir, input logic [1:0] m);
    logic [W-1:0] r;
    logic c;
    r = d;
    c = 1'b0;
    if (m != 2'b11 && s != 0) begin
      if (!dir) begin
        if (m == 2'b01) begin
          r = (d << s) | (d >> (W - s));
          c = r[0];
        end else begin
          r = d << s;
          c = d[W - s];
        end
      end else begin
        if (m == 2'b01) begin
          r = (d >> s) | (d << (W - s));
          c = r[W-1];
        end else if (m == 2'b10) begin
          r = $signed(d) >>> s;
          c = d[s - 1];
        end else begin
          r = d >> s;
          c = d[s - 1];
        end
      end
    end
    return {c, r};
  endfunction

  // Scoreboard: push on accept and check on every consumed result. While
  // the consumer stalls, the output must not change.
  logic [W-1:0] hold_data;
  logic         hold_c;
  logic         stalled = 1'b0;

  always @(negedge clk) begin
    logic [W:0] r;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
`ifdef SHIFTER_CARRY_EN
        check("hold_carry", out_carry, hold_c);
`endif
      end
      if (out_valid && out_ready) begin
        check("out_has_request", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("out_data", out_data, exp_q.pop_front());
`ifdef SHIFTER_CARRY_EN
          check("out_carry", out_carry, exp_c.pop_front());
`else
          void'(exp_c.pop_front());
`endif
        end
        out_count++;
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
`ifdef SHIFTER_CARRY_EN
      hold_c    = out_carry;
`else
      hold_c    = 1'b0;
`endif
      if (in_valid && in_ready) begin
        r = ref_shift(in_data, int'(sl), left_or_right, mode);
        exp_q.push_back(r[W-1:0]);
        exp_c.push_back(r[W]);
        in_count++;
      end
    end
  end

  task automatic rand_req();
    in_data = $urandom;
    if ($urandom_range(0, 3) == 0) sl = ($urandom_range(0, 1) == 0) ? SW'(0) : SW'(W - 1);
    else sl = SW'($urandom_range(0, W - 1));
    left_or_right = 1'($urandom_range(0, 1));
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic directed(input logic [W-1:0] d, input int s, input logic dir,
                          input logic [1:0] m, input logic [W-1:0] e,
                          input logic ec, input string name);
    int n;
    bit seen;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_data = d;
    sl = SW'(s);
    left_or_right = dir;
    mode = m;
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, n, SW);
    check({name, "_out"}, out_data, e);
`ifdef SHIFTER_CARRY_EN
    check({name, "_carry"}, out_carry, ec);
`else
    if (ec !== 1'b0 && ec !== 1'b1) $display("note: %s has no carry expectation", name);
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_io_balance"}, out_count, in_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] r;
    int first, last, nout, stalls, accepts, nvalid;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Hand-computed values that pin the model
    r = ref_shift(32'h8000_0001, 4, 1'b0, 2'b00);
    check("model_lsl4", r, {1'b0, 32'h0000_0010});
    r = ref_shift(32'h8000_0001, 1, 1'b1, 2'b01);
    check("model_ror1", r, {1'b1, 32'hC000_0000});
    r = ref_shift(32'h8000_0001, 31, 1'b0, 2'b01);
    check("model_rol31", r, {1'b0, 32'hC000_0000});
    r = ref_shift(32'hF000_0000, 8, 1'b1, 2'b10);
    check("model_asr_neg", r, {1'b0, 32'hFFF0_0000});

    // Directed vectors with literal expectations
    directed(32'h8000_0001, 4,  1'b0, 2'b00, 32'h0000_0010, 1'b0, "lsl4");
    directed(32'h8000_0001, 1,  1'b1, 2'b01, 32'hC000_0000, 1'b1, "ror1");
    directed(32'h8000_0001, 31, 1'b0, 2'b01, 32'hC000_0000, 1'b0, "rol31");
    directed(32'hF000_0000, 8,  1'b1, 2'b10, 32'hFFF0_0000, 1'b0, "asr_neg");
    directed(32'h7000_0000, 8,  1'b1, 2'b10, 32'h0070_0000, 1'b0, "asr_pos");
    directed(32'h1234_5678, 7,  1'b1, 2'b11, 32'h1234_5678, 1'b0, "pass");
    directed(32'hDEAD_BEEF, 0,  1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0, "sl0_rot");
    directed(32'h8000_0001, 1,  1'b1, 2'b00, 32'h4000_0000, 1'b1, "lsr1");
    directed(32'h8000_0001, 1,  1'b0, 2'b10, 32'h0000_0002, 1'b1, "asl1");
    drain("directed");

    // 32 back-to-back requests with the consumer always ready
    @(posedge clk); #1;
    out_ready = 1'b1;
    first = -1; last = -1; nout = 0; stalls = 0;
    for (int c = 0; c < 32 + SW + 4; c++) begin
      if (c < 32) begin
        in_valid = 1'b1;
        rand_req();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 32 && !in_ready) stalls++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      @(posedge clk); #1;
    end
    check("b2b_stalls", stalls, 0);
    check("b2b_count", nout, 32);
    check("b2b_first", first, SW);
    check("b2b_span", last - first, 31);
    drain("b2b");

    // Consumer stalled for 10 cycles while the producer keeps pushing
    out_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      rand_req();
      @(negedge clk);
      if (in_ready) accepts++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_accepts", accepts, SW);
    check("stall_in_ready_low", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    drain("stall");

    // Random traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_req();
      @(posedge clk); #1;
    end
    drain("random");

    // Reset while 3 requests are in flight
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      rand_req();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_c.delete();
    in_count = 0;
    out_count = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_data, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("rst_no_stale", nvalid, 0);
    directed(32'h0000_00F0, 4, 1'b1, 2'b00, 32'h0000_000F, 1'b0, "post_rst");
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32; data width in bits, a power of two, 8..64.
REQ-002 SHALL have localparam SW = log2(WIDTH); shift-amount width and pipeline depth.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  request present on in_* this cycle.
REQ-006 in_ready  output  1  shifter accepts a request this cycle.
REQ-007 in  input  WIDTH  operand.
REQ-008 sl  input  SW  shift length, unsigned, 0..WIDTH-1.
REQ-009 left_or_right  input  1  direction; 0 = left, 1 = right.
REQ-010 mode  input  2  operation; 00 logical, 01 rotate, 10 arithmetic, 11 pass-through.
REQ-011 out_valid  output  1  result present on out_* this cycle.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out  output  WIDTH  shifted result.
REQ-014 out_carry  output  1  last bit shifted out; present only with SHIFTER_CARRY_EN.

Function
REQ-015 SHALL accept a request when in_valid && in_ready; SHALL present a result when out_valid && out_ready.
REQ-016 SHALL be SW register stages; stage k applies a shift of 2^k when sl[k]=1 and passes data unchanged otherwise; latency exactly SW cycles, handshake to out_valid.
REQ-017 Each stage SHALL hold a valid bit; stage k advances when stage k+1 is empty or advancing; in_ready = !valid_0 || stage 0 advancing; combinational path from out_ready to in_ready allowed.
REQ-018 SHALL sustain one request per cycle when out_ready stays high; no bubbles inserted.
REQ-019 When out_ready=0 with out_valid=1, out, out_carry and out_valid SHALL hold stable until accepted; upstream stages fill, then in_ready drops.
REQ-020 Logical: vacated bits zero-filled, both directions.
REQ-021 Rotate: bits leaving one end re-enter the other; a rotate by sl equals a rotate by sl mod WIDTH.
REQ-022 Arithmetic right: vacated bits filled with in[WIDTH-1]; arithmetic left identical to logical left.
REQ-023 Mode 11: out = in, for any sl and direction.
REQ-024 sl = 0 SHALL give out = in in every mode.
REQ-025 Per-request mode, direction and sl SHALL travel with the data; mixed requests back-to-back produce independent correct results.
REQ-026 out_valid SHALL never rise without a matching accepted request; request count in equals count out.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all stage valid bits, out, out_carry and all pipeline data to 0.
REQ-028 Requests in flight when rst_n asserts SHALL be discarded and never appear at the output.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.

Configuration
REQ-030 Macro SHIFTER_CARRY_EN SHALL compile in out_carry plus one carry bit per stage.
REQ-031 With SHIFTER_CARRY_EN: logical/arithmetic left carry = in[WIDTH-sl]; logical right carry = in[sl-1]; arithmetic right carry = in[sl-1]; rotate left carry = out[0]; rotate right carry = out[WIDTH-1]; carry = 0 when sl=0 or mode 11.
REQ-032 Without SHIFTER_CARRY_EN: port out_carry and carry flops SHALL be absent; all other behaviour unchanged.

Verification (WIDTH=32)
REQ-033 in=32'h8000_0001, sl=4, left, mode 00 -> out=32'h0000_0010 after exactly 5 cycles, carry=0.
REQ-034 in=32'h8000_0001, sl=1, right, mode 01 -> out=32'hC000_0000, carry=1; same in, sl=31, left, mode 01 -> out=32'hC000_0000.
REQ-035 in=32'hF000_0000, sl=8, right, mode 10 -> out=32'hFFF0_0000; in=32'h7000_0000 same -> out=32'h0070_0000.
REQ-036 32 back-to-back requests, random mode/sl, out_ready=1 -> 32 results in consecutive cycles, in order, all matching the reference model.
REQ-037 out_ready held 0 for 10 cycles with pipeline streaming -> in_ready drops after 5 further accepts, out stable, no loss or duplication after release.
REQ-038 rst_n pulsed low mid-stream with 3 requests in flight -> out_valid=0 immediately, no stale result after release, in_ready=1 on the first clock edge.
